axis_record_packer: RTL and testbench
=====================================

AXIS_RECORD_PACKER -- requirements
Module: axis_record_packer

Interface
REQ-001 SHALL have parameter NUM_CHANNELS, default 4, meaning the number of record source channels (2..8).
REQ-002 SHALL have parameter REC_BYTES, default 16, meaning the maximum bytes per record.
REQ-003 SHALL have parameter OUT_BYTES, default 8, meaning the output beat width in bytes (power of 2).
REQ-004 SHALL have parameter ACC_BYTES, default 32, meaning the accumulator capacity; must be >= REC_BYTES+OUT_BYTES.
REQ-005 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous active-low reset.
REQ-007 SHALL have port rec_data, input, NUM_CHANNELS*REC_BYTES*8, per-channel record bytes; byte 0 is oldest.
REQ-008 SHALL have port rec_count, input, NUM_CHANNELS*$clog2(REC_BYTES+1), per-channel valid byte count.
REQ-009 SHALL have port rec_valid, input, NUM_CHANNELS, per-channel record-present flag.
REQ-010 SHALL have port rec_taken, output, NUM_CHANNELS, one-cycle pulse on the channel whose record was accepted.
REQ-011 SHALL have port end_of_stream, input, 1, a level flush request held until eos_done.
REQ-012 SHALL have port eos_done, output, 1, one-cycle pulse when the flush has completed.
REQ-013 SHALL have ports m_tdata (OUT_BYTES*8), m_tkeep (OUT_BYTES), m_tvalid, m_tlast as outputs and m_tready as an input, forming the AXI-Stream master.
REQ-014 SHALL have ports stat_bytes_in and stat_beats_out, output, 32 each, statistics counters (see Configuration).

Function
REQ-015 SHALL grant at most one channel per cycle, round-robin: search starts at pointer rr_ptr, picks the first channel with rec_valid=1, and sets rr_ptr to granted+1 mod NUM_CHANNELS after a grant.
REQ-016 SHALL accept the granted record only in RUN and only when acc_count - (pop?OUT_BYTES:0) + rec_count <= ACC_BYTES; otherwise there is no grant and rr_ptr is unchanged.
REQ-017 SHALL pulse rec_taken in the acceptance cycle and append the record bytes after the existing accumulator bytes; the bytes are visible on m_tdata no earlier than the next cycle.
REQ-018 SHALL take and discard a record with rec_count=0 (rec_taken pulses, no bytes added); counts above REC_BYTES SHALL be clamped to REC_BYTES.
REQ-019 SHALL drive m_tdata with the lowest OUT_BYTES accumulator bytes, with byte 0 in bits [7:0].
REQ-020 SHALL assert m_tvalid in RUN when acc_count >= OUT_BYTES, and in FLUSH when acc_count > 0.
REQ-021 SHALL treat a pop as m_tvalid && m_tready, removing min(OUT_BYTES, acc_count) bytes; a pop and an append in the same cycle are both applied.
REQ-022 SHALL hold m_tdata, m_tkeep and m_tlast stable while m_tvalid=1 and m_tready=0.
REQ-023 SHALL have FSM states RUN, FLUSH and DONE; reset enters RUN.
REQ-024 SHALL go RUN->FLUSH when end_of_stream=1 and not (m_tvalid && !m_tready); new records SHALL NOT be accepted in FLUSH.
REQ-025 SHALL, in FLUSH, set m_tlast=1 and m_tkeep to ones in the low acc_count bits when acc_count <= OUT_BYTES; otherwise m_tkeep is all ones and m_tlast=0.
REQ-026 SHALL go FLUSH->DONE on the pop of the tlast beat, or immediately when acc_count=0 (no beat is emitted); DONE SHALL pulse eos_done for one cycle, then return to RUN.
REQ-027 SHALL keep m_tlast=0 and m_tkeep all ones in RUN.

Reset
REQ-028 SHALL, while reset=0 at a rising edge, set acc_count=0, rr_ptr=0, state=RUN, and drive rec_taken=0, eos_done=0, m_tvalid=0, m_tlast=0, m_tkeep=0, m_tdata=0, and stat counters to 0.
REQ-029 SHALL discard accumulator contents and any in-progress flush when reset is asserted mid-operation, with no partial beat emitted after reset.

Configuration
REQ-030 SHALL, with AXIS_RECORD_PACKER_STATS_EN defined, have stat_bytes_in add the accepted rec_count per acceptance and stat_beats_out increment per pop; both are 32-bit wrapping counters.
REQ-031 SHALL, without AXIS_RECORD_PACKER_STATS_EN, keep both stat ports present and tied to 0, with no counter logic.

Verification
REQ-032 SHALL cover: channels 0-3 each valid with 4-byte records, m_tready=1 -> rec_taken order 0,1,2,3; two full beats emitted, bytes in channel order.
REQ-033 SHALL cover: m_tready=0 with 16-byte records on all channels -> exactly two records accepted (acc=32), then no grants; m_tdata stable; releasing m_tready resumes grants from channel 2.
REQ-034 SHALL cover: 11 bytes accepted, then end_of_stream -> beat 1 keep=0xFF, tlast=0; beat 2 keep=0x07, tlast=1; eos_done pulses one cycle after the tlast pop.
REQ-035 SHALL cover: end_of_stream with acc_count=0 -> no beat emitted; eos_done pulses within 2 cycles.
REQ-036 SHALL cover: reset=0 mid-flush with acc=5 -> m_tvalid=0 the next cycle; state RUN; stat counters 0 (STATS_EN) or always 0 (no STATS_EN).
REQ-037 SHALL cover: only channel 2 valid with rec_count=0 -> rec_taken[2] pulses, acc_count stays 0, rr_ptr=3.

Source files
------------

// File: rtl/axis_record_packer.sv
// Packs variable-length records from NUM_CHANNELS round-robin sources into an AXI-Stream beat stream.
// Optional statistics counters are built only when AXIS_RECORD_PACKER_STATS_EN is defined.
module axis_record_packer #(
    parameter int NUM_CHANNELS = 4,
    parameter int REC_BYTES    = 16,
    parameter int OUT_BYTES    = 8,
    parameter int ACC_BYTES    = 32
) (
    input  logic                                        clk,
    input  logic                                        reset,
    input  logic [NUM_CHANNELS*REC_BYTES*8-1:0]         rec_data,
    input  logic [NUM_CHANNELS*$clog2(REC_BYTES+1)-1:0] rec_count,
    input  logic [NUM_CHANNELS-1:0]                     rec_valid,
    output logic [NUM_CHANNELS-1:0]                     rec_taken,
    input  logic                                        end_of_stream,
    output logic                                        eos_done,
    output logic [OUT_BYTES*8-1:0]                      m_tdata,
    output logic [OUT_BYTES-1:0]                        m_tkeep,
    output logic                                        m_tvalid,
    output logic                                        m_tlast,
    input  logic                                        m_tready,
    output logic [31:0]                                 stat_bytes_in,
    output logic [31:0]                                 stat_beats_out
);
    localparam int CW = $clog2(REC_BYTES + 1);
    localparam int AW = $clog2(ACC_BYTES + 1);
    localparam int PW = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t                 r_state, w_state_nxt;
    logic [ACC_BYTES*8-1:0] r_acc, w_acc_nxt;
    logic [AW-1:0]          r_acc_count, w_count_nxt;
    logic [PW-1:0]          r_rr_ptr;
    logic                   r_rst_q;

    logic [REC_BYTES*8-1:0] w_rec_arr [NUM_CHANNELS];
    logic [CW-1:0]          w_cnt_arr [NUM_CHANNELS];
    logic [PW-1:0]          w_sel, w_idx;
    logic                   w_found, w_fit, w_grant, w_pop, w_tvalid, w_last_beat;
    logic [CW-1:0]          w_cnt_raw, w_cnt;
    logic [REC_BYTES*8-1:0] w_rec_m;
    logic [AW-1:0]          w_pop_n, w_shift_out, w_base;
    logic [OUT_BYTES-1:0]   w_keep_lo;

    for (genvar g = 0; g < NUM_CHANNELS; g++) begin : g_unpack
        assign w_rec_arr[g] = rec_data[g*REC_BYTES*8 +: REC_BYTES*8];
        assign w_cnt_arr[g] = rec_count[g*CW +: CW];
    end

    // Only the first valid channel from rr_ptr is a candidate; if it does not fit, nobody is granted.
    always_comb begin
        w_found = 1'b0;
        w_sel   = '0;
        w_idx   = '0;
        for (int k = 0; k < NUM_CHANNELS; k++) begin
            w_idx = PW'((int'(r_rr_ptr) + k) % NUM_CHANNELS);
            if (!w_found && rec_valid[w_idx]) begin
                w_found = 1'b1;
                w_sel   = w_idx;
            end
        end
    end

    assign w_cnt_raw   = w_cnt_arr[w_sel];
    assign w_cnt       = (w_cnt_raw > CW'(REC_BYTES)) ? CW'(REC_BYTES) : w_cnt_raw;
    assign w_tvalid    = !r_rst_q && (((r_state == RUN) && (r_acc_count >= AW'(OUT_BYTES))) ||
                                      ((r_state == FLUSH) && (r_acc_count != '0)));
    assign w_pop       = w_tvalid && m_tready;
    assign w_pop_n     = (r_acc_count >= AW'(OUT_BYTES)) ? AW'(OUT_BYTES) : r_acc_count;
    assign w_shift_out = w_pop ? w_pop_n : '0;
    assign w_base      = r_acc_count - w_shift_out;
    assign w_fit       = ({1'b0, w_base} + (AW+1)'(w_cnt)) <= (AW+1)'(ACC_BYTES);
    assign w_grant     = (r_state == RUN) && !r_rst_q && w_found && w_fit;

    // Bytes at and above acc_count are kept zero so the append can be a plain OR.
    always_comb begin
        w_rec_m = '0;
        for (int j = 0; j < REC_BYTES; j++)
            if (CW'(j) < w_cnt) w_rec_m[j*8 +: 8] = w_rec_arr[w_sel][j*8 +: 8];
        w_acc_nxt   = r_acc >> {w_shift_out, 3'b000};
        w_count_nxt = w_base;
        if (w_grant) begin
            w_acc_nxt   = w_acc_nxt | ({{((ACC_BYTES-REC_BYTES)*8){1'b0}}, w_rec_m} << {w_base, 3'b000});
            w_count_nxt = w_base + AW'(w_cnt);
        end
    end

    always_comb begin
        w_keep_lo = '0;
        for (int i = 0; i < OUT_BYTES; i++) w_keep_lo[i] = (AW'(i) < r_acc_count);
    end

    assign w_last_beat = (r_state == FLUSH) && (r_acc_count <= AW'(OUT_BYTES));

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            RUN:     if (!r_rst_q && end_of_stream && !(w_tvalid && !m_tready)) w_state_nxt = FLUSH;
            FLUSH:   if ((r_acc_count == '0) || (w_pop && w_last_beat)) w_state_nxt = DONE;
            DONE:    w_state_nxt = RUN;
            default: w_state_nxt = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= RUN;
            r_acc       <= '0;
            r_acc_count <= '0;
            r_rr_ptr    <= '0;
            r_rst_q     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_acc       <= w_acc_nxt;
            r_acc_count <= w_count_nxt;
            r_rst_q     <= 1'b0;
            if (w_grant) r_rr_ptr <= (w_sel == PW'(NUM_CHANNELS-1)) ? '0 : w_sel + 1'b1;
        end
    end

    // r_rst_q holds every output at zero for the cycle following a reset edge.
    assign rec_taken = w_grant ? (NUM_CHANNELS'(1) << w_sel) : '0;
    assign eos_done  = (r_state == DONE);
    assign m_tvalid  = w_tvalid;
    assign m_tdata   = r_rst_q ? '0 : r_acc[OUT_BYTES*8-1:0];
    assign m_tlast   = w_last_beat;
    assign m_tkeep   = r_rst_q ? '0 : (w_last_beat ? w_keep_lo : '1);

`ifdef AXIS_RECORD_PACKER_STATS_EN
    logic [31:0] r_stat_bytes, r_stat_beats;
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_stat_bytes <= '0;
            r_stat_beats <= '0;
        end else begin
            if (w_grant) r_stat_bytes <= r_stat_bytes + 32'(w_cnt);
            if (w_pop)   r_stat_beats <= r_stat_beats + 32'd1;
        end
    end
    assign stat_bytes_in  = r_stat_bytes;
    assign stat_beats_out = r_stat_beats;
`else
    assign stat_bytes_in  = '0;
    assign stat_beats_out = '0;
`endif
endmodule

// File: tb/tb_axis_record_packer.sv
// Directed bench for axis_record_packer: byte/grant scoreboard checked at each sampled cycle.
module tb_axis_record_packer;
    localparam int NC = 4, RB = 16, OB = 8, AB = 32, CW = 5;

    logic                 clk = 1'b0;
    logic                 reset;
    logic [NC*RB*8-1:0]   rec_data;
    logic [NC*CW-1:0]     rec_count;
    logic [NC-1:0]        rec_valid, rec_taken;
    logic                 end_of_stream, eos_done;
    logic [OB*8-1:0]      m_tdata;
    logic [OB-1:0]        m_tkeep;
    logic                 m_tvalid, m_tlast, m_tready;
    logic [31:0]          stat_bytes_in, stat_beats_out;

    axis_record_packer #(.NUM_CHANNELS(NC), .REC_BYTES(RB), .OUT_BYTES(OB), .ACC_BYTES(AB)) dut (
        .clk(clk), .reset(reset), .rec_data(rec_data), .rec_count(rec_count),
        .rec_valid(rec_valid), .rec_taken(rec_taken), .end_of_stream(end_of_stream),
        .eos_done(eos_done), .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid),
        .m_tlast(m_tlast), .m_tready(m_tready), .stat_bytes_in(stat_bytes_in),
        .stat_beats_out(stat_beats_out));

    always #5 clk = ~clk;

    logic [7:0]  rb [NC][RB];
    int          rc [NC];
    logic [7:0]  q[$];
    int          exp_gnt[$];
    int          errors = 0, checks = 0, cyc = 0;
    int          last_pop_cyc = -10, eos_cyc = -10, eos_pulses = 0;
    bit          flushing = 1'b0;
    logic [31:0] model_bytes = 0, model_beats = 0;
    logic [63:0] snap;
    int          start;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic upd();
        for (int c = 0; c < NC; c++) begin
            for (int j = 0; j < RB; j++) rec_data[(c*RB+j)*8 +: 8] = rb[c][j];
            rec_count[c*CW +: CW] = CW'(rc[c]);
        end
    endtask

    task automatic set_rec(input int c, input int cnt, input int base);
        rc[c] = cnt;
        for (int j = 0; j < RB; j++) rb[c][j] = 8'(base + j);
        upd();
        rec_valid[c] = 1'b1;
    endtask

    task automatic chk_stats(input string tag);
`ifdef AXIS_RECORD_PACKER_STATS_EN
        chk({tag, "_bytes_in"}, stat_bytes_in, model_bytes);
        chk({tag, "_beats_out"}, stat_beats_out, model_beats);
`else
        chk({tag, "_bytes_in"}, stat_bytes_in, 0);
        chk({tag, "_beats_out"}, stat_beats_out, 0);
`endif
    endtask

    // One cycle: sample pre-edge outputs, score them, then move to the next negedge.
    task automatic step();
        logic [NC-1:0] take;
        logic          saw_eos;
        logic [63:0]   ed, mask;
        int            n, g;
        logic [7:0]    ek;
        logic          el;
        #1;
        cyc++;
        take    = rec_taken;
        saw_eos = eos_done;
        chk("tvalid", m_tvalid, flushing ? (q.size() > 0) : (q.size() >= OB));
        if (m_tvalid && m_tready) begin
            n  = (q.size() < OB) ? q.size() : OB;
            el = flushing && (q.size() <= OB);
            ek = el ? 8'((1 << q.size()) - 1) : 8'hFF;
            ed = '0; mask = '0;
            for (int i = 0; i < n; i++) begin
                ed[i*8 +: 8]   = q[i];
                mask[i*8 +: 8] = 8'hFF;
            end
            chk("beat_data", m_tdata & mask, ed);
            chk("beat_keep", m_tkeep, ek);
            chk("beat_last", m_tlast, el);
            for (int i = 0; i < n; i++) void'(q.pop_front());
            model_beats++;
            if (el) last_pop_cyc = cyc;
        end
        if (take != '0) begin
            if (exp_gnt.size() == 0) chk("unexpected_grant", take, 0);
            else begin
                g = exp_gnt.pop_front();
                chk("grant", take, 64'(1) << g);
                n = (rc[g] > RB) ? RB : rc[g];
                for (int j = 0; j < n; j++) q.push_back(rb[g][j]);
                model_bytes += 32'(n);
            end
        end
        if (saw_eos) begin
            chk("eos_done_requested", end_of_stream, 1);
            eos_pulses++;
            eos_cyc  = cyc;
            flushing = 1'b0;
        end else if (end_of_stream && !flushing && !(m_tvalid && !m_tready)) flushing = 1'b1;
        @(negedge clk);
        rec_valid = rec_valid & ~take;
        if (saw_eos) end_of_stream = 1'b0;
    endtask

    task automatic drain(input string tag, input int lim);
        int n = 0;
        while ((exp_gnt.size() != 0 || rec_valid != '0 || q.size() >= OB) && n < lim) begin
            step();
            n++;
        end
        chk({tag, "_in_budget"}, n < lim, 1);
    endtask

    task automatic wait_eos(input string tag, input int lim);
        int n = 0;
        int p = eos_pulses;
        while (eos_pulses == p && n < lim) begin
            step();
            n++;
        end
        chk({tag, "_eos_seen"}, eos_pulses != p, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int c = 0; c < NC; c++) begin
            rc[c] = 0;
            for (int j = 0; j < RB; j++) rb[c][j] = 8'h00;
        end
        rec_data = '0; rec_count = '0; rec_valid = '0;
        end_of_stream = 1'b0; m_tready = 1'b1; reset = 1'b0;
        @(negedge clk); @(negedge clk); #1;
        chk("rst_tvalid", m_tvalid, 0);
        chk("rst_tkeep", m_tkeep, 0);
        chk("rst_tdata", m_tdata, 0);
        chk("rst_tlast", m_tlast, 0);
        chk("rst_eos_done", eos_done, 0);
        chk("rst_taken", rec_taken, 0);
        chk_stats("rst");
        reset = 1'b1;

        // Four 4-byte records, no backpressure: grants in channel order, two beats.
        for (int c = 0; c < NC; c++) begin
            set_rec(c, 4, 16*c + 1);
            exp_gnt.push_back(c);
        end
        drain("rr4", 40);
        chk("rr4_empty", q.size(), 0);

        // Backpressure with full records: two fit, then grants stall until space frees.
        m_tready = 1'b0;
        for (int c = 0; c < NC; c++) set_rec(c, 16, 8'h80 + 16*c);
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        step(); step();
        snap = 64'(m_tdata);
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stall_tdata", m_tdata, snap);
            chk("stall_keep", m_tkeep, 8'hFF);
            chk("stall_last", m_tlast, 0);
        end
        chk("stall_two_left", exp_gnt.size(), 0);
        exp_gnt.push_back(2); exp_gnt.push_back(3);
        m_tready = 1'b1;
        drain("bp", 60);
        chk_stats("bp");

        // 11 bytes then flush: 8-byte beat, then 3-byte tlast beat, eos_done right after.
        m_tready = 1'b0;
        set_rec(0, 11, 8'h20);
        exp_gnt.push_back(0);
        step(); step();
        end_of_stream = 1'b1; m_tready = 1'b1;
        wait_eos("flush11", 10);
        chk("flush11_eos_timing", eos_cyc, last_pop_cyc + 1);
        chk("flush11_empty", q.size(), 0);

        // Flush with empty accumulator: no beat, eos_done after RUN->FLUSH->DONE.
        start = cyc;
        snap = 64'(model_beats);
        end_of_stream = 1'b1;
        wait_eos("flush0", 6);
        chk("flush0_latency", eos_cyc - start, 3);
        chk("flush0_no_beat", model_beats, snap);

        // Zero-length record on channel 2 is consumed; next search starts at channel 3.
        set_rec(2, 0, 8'hEE);
        exp_gnt.push_back(2);
        step();
        set_rec(3, 4, 8'h30); set_rec(0, 4, 8'h40);
        exp_gnt.push_back(3); exp_gnt.push_back(0);
        drain("zero", 20);
        // Over-long count is clamped to 16 bytes.
        set_rec(1, 20, 8'h50);
        exp_gnt.push_back(1);
        drain("clamp", 20);
        chk("clamp_empty", q.size(), 0);
        chk_stats("mid");

        // Reset in the middle of a stalled 5-byte flush.
        m_tready = 1'b0;
        set_rec(2, 5, 8'h60);
        exp_gnt.push_back(2);
        step();
        end_of_stream = 1'b1;
        step(); step();
        chk("f5_tvalid", m_tvalid, 1);
        chk("f5_keep", m_tkeep, 8'h1F);
        chk("f5_last", m_tlast, 1);
        reset = 1'b0; end_of_stream = 1'b0;
        @(negedge clk); #1;
        chk("mrst_tvalid", m_tvalid, 0);
        chk("mrst_tkeep", m_tkeep, 0);
        chk("mrst_tdata", m_tdata, 0);
        chk("mrst_eos_done", eos_done, 0);
        model_bytes = 0; model_beats = 0;
        chk_stats("mrst");
        q.delete(); exp_gnt.delete(); flushing = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        m_tready = 1'b1;
        set_rec(1, 8, 8'h70); set_rec(0, 8, 8'hA0);
        exp_gnt.push_back(0); exp_gnt.push_back(1);
        drain("post_rst", 20);
        chk("post_rst_empty", q.size(), 0);
        chk_stats("end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
